// File: rtl/alu_defs.sv
// Shared ALU opcode and sequencer-state definitions, used by both the ALU and
// the control sequencer that drives it.
package alu_defs;

  localparam logic [3:0] OP_IDLE = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_NEG  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;
  localparam logic [3:0] OP_SHRA = 4'b1100;
  localparam logic [3:0] OP_ADD  = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // 0000 is reserved as the ALU "hold" code; 1110/1111 are unassigned.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op != OP_IDLE) && (op != 4'b1110) && (op != 4'b1111);
  endfunction

  function automatic logic is_mul_div(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM: Ra->Y, Rb->bus, ALU->Z, Z->Rd (or LO/HI for MUL/DIV).
// All outputs are registers loaded with the decode of the next state.
module alu_sequencer
  import alu_defs::*;
#(
  parameter int REG_BITS = 4,
  parameter int DATA_W   = 32
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [3:0]          op,
  input  logic [REG_BITS-1:0] ra,
  input  logic [REG_BITS-1:0] rb,
  input  logic [REG_BITS-1:0] rd,
  input  logic [DATA_W-1:0]   bus_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [REG_BITS-1:0] rf_sel,
  output logic                rf_out,
  output logic                rf_in,
  output logic                y_in,
  output logic                z_in,
  output logic                lo_in,
  output logic                hi_in,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic [3:0]          alu_op
);

  typedef struct packed {
    logic [REG_BITS-1:0] rfSel;
    logic                rfOut;
    logic                rfIn;
    logic                yIn;
    logic                zIn;
    logic                loIn;
    logic                hiIn;
    logic                zlowOut;
    logic                zhighOut;
    logic [3:0]          aluOp;
    logic                busy;
    logic                done;
    logic                err;
  } ctrl_t;

  state_t              state, stateNxt;
  logic [3:0]          opQ, opNxt;
  logic [REG_BITS-1:0] raQ, raNxt, rbQ, rbNxt, rdQ, rdNxt;
  logic                errQ, errNxt;
  ctrl_t               ctrlQ, ctrlNxt;

  // Moore decode; aluOp is non-zero only in T2 so the ALU sees exactly one edge.
  function automatic ctrl_t decode(input state_t s, input logic [3:0] o,
                                   input logic [REG_BITS-1:0] a,
                                   input logic [REG_BITS-1:0] b,
                                   input logic [REG_BITS-1:0] d,
                                   input logic e);
    ctrl_t c;
    c = '0;
    case (s)
      S_T0: begin
        c.rfSel = a; c.rfOut = 1'b1; c.yIn = 1'b1; c.busy = 1'b1;
      end
      S_T1: begin
        c.rfSel = b; c.rfOut = 1'b1; c.busy = 1'b1;
      end
      S_T2: begin
        c.rfSel = b; c.rfOut = 1'b1; c.aluOp = o; c.zIn = 1'b1; c.busy = 1'b1;
      end
      S_T3: begin
        c.zlowOut = 1'b1; c.busy = 1'b1;
        if (is_mul_div(o)) c.loIn = 1'b1;
        else begin
          c.rfSel = d; c.rfIn = 1'b1;
        end
      end
      S_T4: begin
        c.zhighOut = 1'b1; c.hiIn = 1'b1; c.busy = 1'b1;
      end
      S_DONE: begin
        c.done = 1'b1; c.err = e;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    stateNxt = state;
    opNxt    = opQ;
    raNxt    = raQ;
    rbNxt    = rbQ;
    rdNxt    = rdQ;
    errNxt   = errQ;
    case (state)
      S_IDLE: if (start) begin
        opNxt    = op;
        raNxt    = ra;
        rbNxt    = rb;
        rdNxt    = rd;
        errNxt   = !is_legal_op(op);
        stateNxt = is_legal_op(op) ? S_T0 : S_DONE;
      end
      S_T0: stateNxt = S_T1;
      // Rb is on the bus in T1, so a zero divisor is caught before Z is loaded.
      S_T1: begin
        if (opQ == OP_DIV && bus_in == '0) begin
          errNxt   = 1'b1;
          stateNxt = S_DONE;
        end else begin
          stateNxt = S_T2;
        end
      end
      S_T2:    stateNxt = S_T3;
      S_T3:    stateNxt = is_mul_div(opQ) ? S_T4 : S_DONE;
      S_T4:    stateNxt = S_DONE;
      S_DONE:  stateNxt = S_IDLE;
      default: stateNxt = S_IDLE;
    endcase
  end

  always_comb ctrlNxt = decode(stateNxt, opNxt, raNxt, rbNxt, rdNxt, errNxt);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      opQ   <= '0;
      raQ   <= '0;
      rbQ   <= '0;
      rdQ   <= '0;
      errQ  <= 1'b0;
      ctrlQ <= '0;
    end else begin
      state <= stateNxt;
      opQ   <= opNxt;
      raQ   <= raNxt;
      rbQ   <= rbNxt;
      rdQ   <= rdNxt;
      errQ  <= errNxt;
      ctrlQ <= ctrlNxt;
    end
  end

  assign rf_sel    = ctrlQ.rfSel;
  assign rf_out    = ctrlQ.rfOut;
  assign rf_in     = ctrlQ.rfIn;
  assign y_in      = ctrlQ.yIn;
  assign z_in      = ctrlQ.zIn;
  assign lo_in     = ctrlQ.loIn;
  assign hi_in     = ctrlQ.hiIn;
  assign zlow_out  = ctrlQ.zlowOut;
  assign zhigh_out = ctrlQ.zhighOut;
  assign alu_op    = ctrlQ.aluOp;
  assign busy      = ctrlQ.busy;
  assign done      = ctrlQ.done;
  assign err       = ctrlQ.err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural datapath
// (regfile, Y, Z, LO, HI, ALU) closing the bus loop.
module tb_alu_sequencer;
  import alu_defs::*;

  localparam int REG_BITS = 4;
  localparam int DATA_W   = 32;

  logic                clock, clear, start;
  logic [3:0]          op;
  logic [REG_BITS-1:0] ra, rb, rd;
  logic [DATA_W-1:0]   bus;
  logic                busy, done, err;
  logic [REG_BITS-1:0] rf_sel;
  logic                rf_out, rf_in, y_in, z_in, lo_in, hi_in, zlow_out, zhigh_out;
  logic [3:0]          alu_op;

  alu_sequencer #(.REG_BITS(REG_BITS), .DATA_W(DATA_W)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .ra(ra), .rb(rb), .rd(rd), .bus_in(bus),
    .busy(busy), .done(done), .err(err), .rf_sel(rf_sel),
    .rf_out(rf_out), .rf_in(rf_in), .y_in(y_in), .z_in(z_in),
    .lo_in(lo_in), .hi_in(hi_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .alu_op(alu_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DATA_W-1:0] R [16];
  logic [DATA_W-1:0] Y, LO, HI;
  logic [63:0]       Z;
  logic              preWe;
  logic [3:0]        preAddr;
  logic [DATA_W-1:0] preData;

  function automatic logic [63:0] aluf(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      OP_ADD:  return {32'd0, a + b};
      OP_SUB:  return {32'd0, a - b};
      OP_MUL:  return {32'd0, a} * {32'd0, b};
      OP_DIV:  return (b != 0) ? {a % b, a / b} : 64'd0;
      OP_AND:  return {32'd0, a & b};
      OP_OR:   return {32'd0, a | b};
      default: return 64'd0;
    endcase
  endfunction

  always_comb begin
    bus = '0;
    if (rf_out)         bus = R[rf_sel];
    else if (zlow_out)  bus = Z[31:0];
    else if (zhigh_out) bus = Z[63:32];
  end

  always_ff @(posedge clock) begin
    if (preWe) R[preAddr] <= preData;
    if (rf_in) R[rf_sel]  <= bus;
    if (y_in)  Y  <= bus;
    if (z_in)  Z  <= aluf(alu_op, Y, bus);
    if (lo_in) LO <= bus;
    if (hi_in) HI <= bus;
  end

  int nCmp = 0, nErr = 0;
  int aluBad = 0, busBad = 0, errBad = 0;

  // Continuous rules: ALU hold code outside the Z-load cycle, single bus driver, err only with done.
  always @(negedge clock) if (clear) begin
    if (alu_op != OP_IDLE && !z_in) aluBad++;
    if ((32'(rf_out) + 32'(zlow_out) + 32'(zhigh_out)) > 1) busBad++;
    if (err && !done) errBad++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] en8();
    return {rf_out, rf_in, y_in, z_in, lo_in, hi_in, zlow_out, zhigh_out};
  endfunction

  function automatic logic [18:0] ctl();
    return {rf_sel, en8(), alu_op, busy, done, err};
  endfunction

  function automatic logic [18:0] mk(input logic [3:0] sel, input logic [7:0] en,
                                     input logic [3:0] aop, input logic [2:0] bde);
    return {sel, en, aop, bde};
  endfunction

  logic [18:0] trace [1:20];

  task automatic setReg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock); preWe = 1'b1; preAddr = a; preData = d;
    @(negedge clock); preWe = 1'b0;
  endtask

  task automatic runOp(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, output int lat, output logic errD,
                       output logic [7:0] enSeen);
    @(negedge clock); start = 1'b1; op = o; ra = a; rb = b; rd = d;
    @(posedge clock); #1 start = 1'b0;
    lat = 99; errD = 1'b0; enSeen = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      trace[c] = ctl();
      enSeen |= en8();
      if (done) begin
        lat = c; errD = err;
        break;
      end
    end
  endtask

  int          lat, doneCyc, busyCyc, done2;
  logic        errD;
  logic [7:0]  enSeen;
  logic [3:0]  aop3;
  logic [31:0] loSave, hiSave;

  initial begin
    clear = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rd = '0;
    preWe = 1'b0; preAddr = '0; preData = '0;
    repeat (2) @(negedge clock);
    chk("rst_outs", 64'(ctl()), 64'd0);
    clear = 1'b1;

    // ADD R3 = R1 + R2
    setReg(1, 32'd5); setReg(2, 32'd7);
    runOp(OP_ADD, 1, 2, 3, lat, errD, enSeen);
    chk("add_lat", lat, 5);
    chk("add_err", errD, 0);
    chk("add_t0", trace[1], mk(4'd1, 8'b1010_0000, 4'd0, 3'b100));
    chk("add_t1", trace[2], mk(4'd2, 8'b1000_0000, 4'd0, 3'b100));
    chk("add_t2", trace[3], mk(4'd2, 8'b1001_0000, OP_ADD, 3'b100));
    chk("add_t3", trace[4], mk(4'd3, 8'b0100_0010, 4'd0, 3'b100));
    chk("add_r3", R[3], 32'd12);

    // MUL 0x10000 * 0x10000 -> HI=1, LO=0, no register write-back
    setReg(4, 32'h0001_0000); setReg(5, 32'h0001_0000); setReg(6, 32'hA5A5);
    runOp(OP_MUL, 4, 5, 6, lat, errD, enSeen);
    chk("mul_lat", lat, 6);
    chk("mul_err", errD, 0);
    chk("mul_lo", LO, 32'd0);
    chk("mul_hi", HI, 32'd1);
    chk("mul_en", enSeen, 8'b1011_1111);
    chk("mul_rd", R[6], 32'hA5A5);

    // DIV by zero stops after T1
    setReg(5, 32'd0); setReg(9, 32'h1234);
    loSave = LO; hiSave = HI;
    runOp(OP_DIV, 4, 5, 9, lat, errD, enSeen);
    chk("div0_lat", lat, 3);
    chk("div0_err", errD, 1);
    chk("div0_en", enSeen, 8'b1010_0000);
    chk("div0_lo", LO, 64'(loSave));
    chk("div0_hi", HI, 64'(hiSave));
    chk("div0_rd", R[9], 32'h1234);

    // Illegal opcodes: immediate done+err, no enables
    runOp(4'b1111, 1, 2, 10, lat, errD, enSeen);
    chk("ill15_lat", lat, 1);
    chk("ill15_ctl", trace[1], mk(4'd0, 8'd0, 4'd0, 3'b011));
    chk("ill15_en", enSeen, 0);
    runOp(4'b0000, 1, 2, 10, lat, errD, enSeen);
    chk("ill0_lat", lat, 1);
    chk("ill0_err", errD, 1);
    runOp(4'b1110, 1, 2, 10, lat, errD, enSeen);
    chk("ill14_en", {lat[7:0], 7'd0, errD, enSeen}, {8'd1, 7'd0, 1'b1, 8'd0});

    // Inputs changing while busy; start held high restarts after one idle cycle
    @(negedge clock); start = 1'b1; op = OP_ADD; ra = 1; rb = 2; rd = 11;
    @(posedge clock);
    doneCyc = 0; busyCyc = 0; done2 = 0; aop3 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      case (c)
        1: begin start = 1'b0; op = OP_SUB; end
        2: start = 1'b1;
        3: begin start = 1'b0; op = OP_OR; end
        4: begin start = 1'b1; op = OP_SUB; ra = 2; rb = 1; rd = 12; end
        default: ;
      endcase
      if (c == 3) aop3 = alu_op;
      if (done && doneCyc == 0) doneCyc = c;
      else if (busy && doneCyc != 0 && busyCyc == 0) busyCyc = c;
      else if (done && doneCyc != 0 && c > doneCyc) begin
        done2 = c;
        break;
      end
    end
    start = 1'b0;
    chk("b2b_aop", aop3, OP_ADD);
    chk("b2b_done1", doneCyc, 5);
    chk("b2b_restart", busyCyc, 7);
    chk("b2b_done2", done2, 11);
    chk("b2b_r11", R[11], 32'd12);
    chk("b2b_r12", R[12], 32'd2);

    // Reset asserted during T2 of SUB
    setReg(8, 32'hDEAD);
    @(negedge clock); start = 1'b1; op = OP_SUB; ra = 1; rb = 2; rd = 8;
    @(posedge clock); #1 start = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_in_t2", {z_in, alu_op}, {1'b1, OP_SUB});
    clear = 1'b0;
    #1 chk("mid_outs", 64'(ctl()), 64'd0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    repeat (2) @(negedge clock);
    chk("mid_r8", R[8], 32'hDEAD);
    chk("mid_idle", busy, 0);
    runOp(OP_ADD, 1, 2, 8, lat, errD, enSeen);
    chk("mid_next_lat", lat, 5);
    chk("mid_next_r8", R[8], 32'd12);

    chk("aluop_hold", aluBad, 0);
    chk("bus_single", busBad, 0);
    chk("err_wo_done", errBad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
